rs232rx: RTL and testbench

//   8N1 asynchronous serial receiver, companion to the rs232tx transmitter.

---
 rtl/rs232rx.sv | 130 +++++++++++++
 tb/tb_rs232rx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs232rx.sv
// 8N1 serial receiver: synchronises serial_in, samples at mid-bit and checks the stop bit.
// valid rises about 9.5 bit times + 3 clocks after the start edge; a full register drops the new byte and sets overrun.
module rs232rx #(
  parameter int unsigned bps       = 0,
  parameter int unsigned frequency = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       serial_in,
  output logic [7:0] d,
  output logic       valid,
  input  logic       re,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  // bps=0 is an unset parameter; guard the divide so elaboration still succeeds.
  localparam int unsigned bps_div = (bps == 0) ? 1 : bps;
  localparam int unsigned period  = (frequency + bps_div / 2) / bps_div;
  localparam logic [CNT_W-1:0] full_ld = CNT_W'(period - 1);
  localparam logic [CNT_W-1:0] half_ld = CNT_W'(period / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t           state, state_nxt;
  logic             rx_m, rx_s;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_cnt, bit_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             deliver, deliver_nxt;
  logic             ferr_nxt;
  logic             tick;

  assign tick = (cnt == '0);
  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_m          <= 1'b1;
      rx_s          <= 1'b1;
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      deliver       <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_m          <= serial_in;
      rx_s          <= rx_m;
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bit_cnt       <= bit_nxt;
      shift         <= shift_nxt;
      deliver       <= deliver_nxt;
      framing_error <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = tick ? cnt : cnt - CNT_W'(1);
    bit_nxt     = bit_cnt;
    shift_nxt   = shift;
    deliver_nxt = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_nxt   = half_ld;
          state_nxt = START;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = full_ld;
            bit_nxt   = 3'd0;
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_nxt = {rx_s, shift[7:1]};
          cnt_nxt   = full_ld;
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        // Deciding at mid stop bit leaves half a bit to re-arm for a back-to-back start.
        if (tick) begin
          if (rx_s) begin
            deliver_nxt = 1'b1;
            state_nxt   = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d       <= 8'h00;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (deliver && (!valid || re)) begin
        d     <= shift;
        valid <= 1'b1;
      end else if (re) begin
        valid <= 1'b0;
      end
      if (deliver && valid && !re) overrun <= 1'b1;
      else if (re)                 overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs232rx.sv
// Bench for rs232rx at 16 clocks per bit: directed scenarios plus random frames against a holding-register model.
module tb_rs232rx;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       serial_in;
  logic [7:0] d;
  logic       valid;
  logic       re;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fe_pulses = 0, fe_run = 0, fe_maxlen = 0;
  logic fe_prev = 1'b0, valid_prev = 1'b0;
  int valid_rise_cyc = -1;

  rs232rx #(.bps(1_000_000), .frequency(16_000_000), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .serial_in(serial_in), .d(d), .valid(valid),
    .re(re), .framing_error(framing_error), .overrun(overrun), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  always @(negedge clock) begin
    if (framing_error) begin
      if (!fe_prev) fe_pulses++;
      fe_run++;
      if (fe_run > fe_maxlen) fe_maxlen = fe_run;
    end else begin
      fe_run = 0;
    end
    fe_prev = framing_error;
    if (valid && !valid_prev) valid_rise_cyc = cyc;
    valid_prev = valid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required completion before 2ms");
    $fatal(1);
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    serial_in = 1'b0;
    tick_n(16);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      tick_n(16);
    end
    serial_in = stop_bit;
    tick_n(16);
  endtask

  task automatic pulse_re();
    re = 1'b1;
    tick_n(1);
    re = 1'b0;
    tick_n(1);
  endtask

  task automatic test_reset();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", valid); end
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_d: got %h expected 00", d); end
    checks++; if (framing_error !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rst_err: got fe=%b ov=%b expected 0 0", framing_error, overrun); end
    reset_n = 1'b1;
    tick_n(5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    int c0, fe0;
    fe0 = fe_pulses;
    valid_rise_cyc = -1;
    c0 = cyc;
    send_frame(8'hA5, 1'b1);
    tick_n(4);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL t1_valid: got %b expected 1", valid); end
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL t1_d: got %h expected a5", d); end
    checks++; if (valid_rise_cyc - c0 < 150 || valid_rise_cyc - c0 > 160) begin errors++; $display("FAIL t1_latency: got %0d expected 150..160", valid_rise_cyc - c0); end
    checks++; if (fe_pulses != fe0 || overrun !== 1'b0) begin errors++; $display("FAIL t1_err: got fe_pulses=%0d ov=%b expected %0d 0", fe_pulses, overrun, fe0); end
    pulse_re();
    checks++; if (valid !== 1'b0 || d !== 8'hA5) begin errors++; $display("FAIL t1_read: got valid=%b d=%h expected 0 a5", valid, d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [2];
    int fe0;
    exp_b[0] = 8'h00;
    exp_b[1] = 8'hFF;
    fe0 = fe_pulses;
    tick_n(20);
    fork
      begin
        send_frame(exp_b[0], 1'b1);
        send_frame(exp_b[1], 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          bit got;
          got = 1'b0;
          for (int i = 0; i < 400 && !got; i++) begin
            tick_n(1);
            if (valid === 1'b1) got = 1'b1;
          end
          checks++;
          if (!got) begin errors++; $display("FAIL b2b_timeout%0d: got no valid expected valid within 400 clk", k); end
          else if (d !== exp_b[k]) begin errors++; $display("FAIL b2b_d%0d: got %h expected %h", k, d, exp_b[k]); end
          pulse_re();
        end
      end
    join
    tick_n(4);
    checks++; if (valid !== 1'b0 || overrun !== 1'b0 || fe_pulses != fe0) begin errors++; $display("FAIL b2b_end: got valid=%b ov=%b fe_pulses=%0d expected 0 0 %0d", valid, overrun, fe_pulses, fe0); end
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_pulses;
    tick_n(20);
    serial_in = 1'b0;
    tick_n(5);
    serial_in = 1'b1;
    tick_n(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi: got %b expected 1", busy); end
    tick_n(30);
    checks++; if (busy !== 1'b0 || valid !== 1'b0 || fe_pulses != fe0) begin errors++; $display("FAIL glitch_idle: got busy=%b valid=%b fe_pulses=%0d expected 0 0 %0d", busy, valid, fe_pulses, fe0); end
  endtask

  task automatic test_framing();
    int fe0;
    fe0 = fe_pulses;
    fe_maxlen = 0;
    send_frame(8'h3C, 1'b0);
    tick_n(40);
    checks++; if (fe_pulses != fe0 + 1 || fe_maxlen != 1) begin errors++; $display("FAIL fe_pulse: got pulses=%0d len=%0d expected %0d 1", fe_pulses - fe0, fe_maxlen, 1); end
    checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fe_hold: got valid=%b busy=%b expected 0 1", valid, busy); end
    serial_in = 1'b1;
    tick_n(20);
    send_frame(8'h11, 1'b1);
    tick_n(2);
    checks++; if (valid !== 1'b1 || d !== 8'h11) begin errors++; $display("FAIL fe_next: got valid=%b d=%h expected 1 11", valid, d); end
    pulse_re();
  endtask

  task automatic test_overrun();
    tick_n(10);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    tick_n(2);
    checks++; if (d !== 8'h12 || valid !== 1'b1) begin errors++; $display("FAIL ov_d: got d=%h valid=%b expected 12 1", d, valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ov_flag: got %b expected 1", overrun); end
    pulse_re();
    checks++; if (valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL ov_clear: got valid=%b ov=%b expected 0 0", valid, overrun); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'h5A;
    send_frame(8'h77, 1'b1);
    tick_n(2);
    serial_in = 1'b0;
    tick_n(16);
    for (int i = 0; i < 4; i++) begin
      serial_in = b[i];
      tick_n(16);
    end
    serial_in = b[4];
    tick_n(8);
    checks++; if (busy !== 1'b1 || valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got busy=%b valid=%b expected 1 1", busy, valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (valid !== 1'b0 || d !== 8'h00 || busy !== 1'b0 || overrun !== 1'b0 || framing_error !== 1'b0)
      begin errors++; $display("FAIL mid_async: got valid=%b d=%h busy=%b ov=%b fe=%b expected all 0", valid, d, busy, overrun, framing_error); end
    tick_n(3);
    serial_in = 1'b1;
    reset_n = 1'b1;
    tick_n(60);
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_idle: got valid=%b busy=%b expected 0 0", valid, busy); end
    send_frame(b, 1'b1);
    tick_n(2);
    checks++; if (valid !== 1'b1 || d !== 8'h5A) begin errors++; $display("FAIL mid_next: got valid=%b d=%h expected 1 5a", valid, d); end
    pulse_re();
  endtask

  // Reference: a one-entry holding register fed by whole frames and drained by reads.
  task automatic test_random();
    logic [7:0] md, b;
    logic mv, mo;
    md = 8'h5A;
    mv = 1'b0;
    mo = 1'b0;
    for (int n = 0; n < 14; n++) begin
      b = 8'($urandom_range(0, 255));
      tick_n($urandom_range(0, 20));
      send_frame(b, 1'b1);
      if (mv) mo = 1'b1;
      else begin md = b; mv = 1'b1; end
      tick_n(1);
      checks++; if (d !== md || valid !== mv || overrun !== mo)
        begin errors++; $display("FAIL rnd%0d: got d=%h v=%b ov=%b expected %h %b %b", n, d, valid, overrun, md, mv, mo); end
      if ($urandom_range(0, 2) != 0) begin
        pulse_re();
        mv = 1'b0;
        mo = 1'b0;
        checks++; if (valid !== 1'b0 || overrun !== 1'b0)
          begin errors++; $display("FAIL rnd_read%0d: got v=%b ov=%b expected 0 0", n, valid, overrun); end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    serial_in = 1'b1;
    re = 1'b0;
    tick_n(3);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
